// File: rtl/uram_pkg.sv
// Shared URAM288 geometry constants, init FSM encoding and word-packing helper.
// Pure declarations; no latency or backpressure of its own.
package uram_pkg;

    localparam int URAM_ROW_BITS  = 72;
    localparam int URAM_ADDR_BITS = 23;
    localparam int URAM_ROWS      = 4096;
    localparam int URAM_BWE_BITS  = 9;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    // Words of the given width that fit in the 64 data bits of one row.
    function automatic int words_per_row(input int data_width);
        return 64 / data_width;
    endfunction

endpackage

// File: rtl/uram_read_pipe.sv
// Read-side tracking: valid shifted over LATENCY stages, tag (lane + bypass) over the two primitive stages.
// Latency: out_vld LATENCY cycles after in_vld, sel_tag aligned with primitive output; no backpressure.
module uram_read_pipe #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] sel_tag,
    output logic             out_vld
);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]   tag0_q, tag0_d;
    logic [TAG_W-1:0]   tag1_q, tag1_d;

    always_comb begin
        vld_d  = {vld_q[LATENCY-2:0], in_vld};
        tag0_d = in_tag;
        tag1_d = tag0_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= '0;
            tag0_q <= '0;
            tag1_q <= '0;
        end else begin
            vld_q  <= vld_d;
            tag0_q <= tag0_d;
            tag1_q <= tag1_d;
        end
    end

    assign sel_tag = tag1_q;
    assign out_vld = vld_q[LATENCY-1];

endmodule

// File: rtl/uram_packed_mem.sv
// Word-addressed simple dual-port memory packing several narrow words into each 72-bit URAM row.
// Latency: READ_LATENCY cycles ren->rvalid, one read and one write per cycle; requests ignored until init_done.
module uram_packed_mem
    import uram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 16,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_FIRST   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ren,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic                     rvalid,
    output logic [DATA_WIDTH-1:0]    dout,
    input  logic                     wen,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic                     init_done
);

    localparam int WPR    = words_per_row(DATA_WIDTH);
    localparam int LW     = $clog2(WPR);
    localparam int LANE_W = (LW == 0) ? 1 : LW;
    localparam int ROW_W  = ADDRESS_WIDTH - LW;
    localparam int BPW    = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(URAM_ROWS);
    localparam int BASE_W = $clog2(URAM_ROW_BITS);
    localparam bit USE_BEHAV_MODEL = 1'b1;

    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("uram_packed_mem: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (READ_LATENCY < 2 || READ_LATENCY > 4) begin : g_bad_lat
        $error("uram_packed_mem: READ_LATENCY must be 2, 3 or 4");
    end
    if (ADDRESS_WIDTH <= LW || ADDRESS_WIDTH > IDX_W + LW) begin : g_bad_aw
        $error("uram_packed_mem: ADDRESS_WIDTH does not fit one URAM");
    end
    if (WRITE_FIRST != 0 && WRITE_FIRST != 1) begin : g_bad_wf
        $error("uram_packed_mem: WRITE_FIRST must be 0 or 1");
    end

    init_state_e      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        if (state_q == ST_INIT) begin
            row_d = row_q + 1'b1;
            if (&row_q) state_d = ST_READY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    assign init_done = (state_q == ST_READY);

    logic              rd_acc, wr_acc, rd_byp;
    logic [LANE_W-1:0] r_lane, w_lane;

    assign rd_acc = ren && (state_q == ST_READY);
    assign wr_acc = wen && (state_q == ST_READY);
    assign r_lane = LANE_W'(raddr & ADDRESS_WIDTH'(WPR - 1));
    assign w_lane = LANE_W'(waddr & ADDRESS_WIDTH'(WPR - 1));
    // The primitive reads before it writes, so new data on a same-address hit must be forwarded.
    assign rd_byp = (WRITE_FIRST != 0) && rd_acc && wr_acc && (raddr == waddr);

    logic                      en_a, en_b;
    logic [URAM_ADDR_BITS-1:0] addr_a, addr_b;
    logic [URAM_BWE_BITS-1:0]  bwe_b;
    logic [URAM_ROW_BITS-1:0]  din_b, dout_a;

    assign en_a   = rd_acc;
    assign addr_a = URAM_ADDR_BITS'(raddr >> LW);

    always_comb begin
        en_b   = 1'b0;
        bwe_b  = '0;
        addr_b = URAM_ADDR_BITS'(row_q);
        din_b  = '0;
        if (state_q == ST_INIT) begin
            en_b  = 1'b1;
            bwe_b = '1;
        end else if (wr_acc) begin
            en_b   = 1'b1;
            addr_b = URAM_ADDR_BITS'(waddr >> LW);
            din_b  = {8'h00, {WPR{din}}};
            for (int i = 0; i < WPR; i++) begin
                if (LANE_W'(i) == w_lane) bwe_b[i*BPW +: BPW] = '1;
            end
        end
    end

    if (USE_BEHAV_MODEL) begin : g_model
        logic [URAM_ROW_BITS-1:0] mem [URAM_ROWS];
        logic [URAM_ROW_BITS-1:0] lat_q, oreg_q;
        logic                     a_hit, b_hit;

        assign a_hit = en_a && (addr_a[URAM_ADDR_BITS-1:IDX_W] == '0);
        assign b_hit = en_b && (addr_b[URAM_ADDR_BITS-1:IDX_W] == '0);

        always_ff @(posedge clock) begin
            if (a_hit) lat_q <= mem[addr_a[IDX_W-1:0]];
            oreg_q <= lat_q;
            if (b_hit) begin
                for (int i = 0; i < URAM_BWE_BITS; i++) begin
                    if (bwe_b[i]) mem[addr_b[IDX_W-1:0]][i*8 +: 8] <= din_b[i*8 +: 8];
                end
            end
        end

        assign dout_a = oreg_q;
    end else begin : g_prim
        URAM288_BASE #(
            .IREG_PRE_A ("FALSE"),
            .IREG_PRE_B ("FALSE"),
            .OREG_A     ("TRUE"),
            .OREG_B     ("TRUE"),
            .OREG_ECC_A ("FALSE"),
            .OREG_ECC_B ("FALSE")
        ) u_uram (
            .CLK              (clock),
            .SLEEP            (1'b0),
            .ADDR_A           (addr_a),
            .BWE_A            ('0),
            .DIN_A            ('0),
            .DOUT_A           (dout_a),
            .EN_A             (en_a),
            .RDB_WR_A         (1'b0),
            .RST_A            (1'b0),
            .OREG_CE_A        (1'b1),
            .OREG_ECC_CE_A    (1'b0),
            .INJECT_SBITERR_A (1'b0),
            .INJECT_DBITERR_A (1'b0),
            .DBITERR_A        (),
            .SBITERR_A        (),
            .RDACCESS_A       (),
            .ADDR_B           (addr_b),
            .BWE_B            (bwe_b),
            .DIN_B            (din_b),
            .DOUT_B           (),
            .EN_B             (en_b),
            .RDB_WR_B         (1'b1),
            .RST_B            (1'b0),
            .OREG_CE_B        (1'b1),
            .OREG_ECC_CE_B    (1'b0),
            .INJECT_SBITERR_B (1'b0),
            .INJECT_DBITERR_B (1'b0),
            .DBITERR_B        (),
            .SBITERR_B        (),
            .RDACCESS_B       ()
        );
    end

    logic [LANE_W:0]       sel_tag;
    logic [LANE_W-1:0]     sel_lane;
    logic                  sel_byp, pipe_vld;
    logic [BASE_W-1:0]     sel_base;
    logic [DATA_WIDTH-1:0] byp0_q, byp1_q, sel_dat, fab_dat;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    uram_read_pipe #(
        .LATENCY (READ_LATENCY),
        .TAG_W   (LANE_W + 1)
    ) u_read_pipe (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (rd_acc),
        .in_tag  ({rd_byp, r_lane}),
        .sel_tag (sel_tag),
        .out_vld (pipe_vld)
    );

    always_ff @(posedge clock) begin
        byp0_q <= din;
        byp1_q <= byp0_q;
    end

    assign {sel_byp, sel_lane} = sel_tag;
    assign sel_base = BASE_W'(sel_lane) * BASE_W'(DATA_WIDTH);
    assign sel_dat  = sel_byp ? byp1_q : dout_a[sel_base +: DATA_WIDTH];

    if (READ_LATENCY == 2) begin : g_no_fab
        assign fab_dat = sel_dat;
    end else begin : g_fab
        logic [DATA_WIDTH-1:0] fab_q [READ_LATENCY-2];
        always_ff @(posedge clock) begin
            fab_q[0] <= sel_dat;
            for (int k = 1; k < READ_LATENCY - 2; k++) fab_q[k] <= fab_q[k-1];
        end
        assign fab_dat = fab_q[READ_LATENCY-3];
    end

    always_comb begin
        dout_d = pipe_vld ? fab_dat : dout_q;
    end

    always_ff @(posedge clock) begin
        if (reset) dout_q <= '0;
        else       dout_q <= dout_d;
    end

    assign rvalid = pipe_vld;
    assign dout   = dout_d;

endmodule

// File: tb/tb_uram_packed_mem.sv
// Scoreboard bench: default instance plus a 32-bit / latency-4 / write-first instance on shared stimulus.
// Expected reads come from plain word arrays; a negedge monitor pops and compares.
module tb_uram_packed_mem;

    logic        clock = 1'b0;
    logic        reset, ren, wen;
    logic [13:0] raddr, waddr;
    logic [31:0] din;
    logic        rvalid0, init_done0, rvalid1, init_done1;
    logic [15:0] dout0;
    logic [31:0] dout1;

    always #5 clock = ~clock;

    uram_packed_mem u_dut0 (
        .clock     (clock),
        .reset     (reset),
        .ren       (ren),
        .raddr     (raddr),
        .rvalid    (rvalid0),
        .dout      (dout0),
        .wen       (wen),
        .waddr     (waddr),
        .din       (din[15:0]),
        .init_done (init_done0)
    );

    uram_packed_mem #(
        .ADDRESS_WIDTH (13),
        .DATA_WIDTH    (32),
        .READ_LATENCY  (4),
        .WRITE_FIRST   (1)
    ) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .ren       (ren),
        .raddr     (raddr[12:0]),
        .rvalid    (rvalid1),
        .dout      (dout1),
        .wen       (wen),
        .waddr     (waddr[12:0]),
        .din       (din),
        .init_done (init_done1)
    );

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] m0 [0:16383];
    logic [31:0] m1 [0:8191];
    logic [31:0] last_v [2];
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic        ready = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic mon(input int k, input logic rv, input logic [31:0] dv);
        exp_t e;
        int   n;
        logic ev;
        e.due = 0;
        e.dat = '0;
        n = (k == 0) ? q0.size() : q1.size();
        if (n > 0) e = (k == 0) ? q0[0] : q1[0];
        ev = (n > 0) && (e.due == cyc);
        chk($sformatf("rvalid%0d", k), {31'd0, rv}, {31'd0, ev});
        if (ev) begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (rv) chk($sformatf("dout%0d", k), dv, e.dat);
            last_v[k] = e.dat;
        end else begin
            if (!rv) chk($sformatf("dout_hold%0d", k), dv, last_v[k]);
            if (n > 0 && e.due < cyc) begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            mon(0, rvalid0, {16'h0, dout0});
            mon(1, rvalid1, dout1);
        end
    end

    // One cycle of stimulus; the model answers reads from word arrays before applying the write.
    task automatic drive(input logic r, input logic [13:0] ra, input logic w,
                         input logic [13:0] wa, input logic [31:0] d);
        logic [15:0] e0;
        logic [31:0] e1;
        ren = r; raddr = ra; wen = w; waddr = wa; din = d;
        if (ready) begin
            if (r) begin
                e0 = m0[ra];
                e1 = (w && wa[12:0] == ra[12:0]) ? d : m1[ra[12:0]];
                q0.push_back('{due: cyc + 2, dat: {16'h0, e0}});
                q1.push_back('{due: cyc + 4, dat: e1});
            end
            if (w) begin
                m0[wa]       = d[15:0];
                m1[wa[12:0]] = d;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        int n, n0, n1;
        reset = 1'b1; ren = 1'b0; wen = 1'b0; ready = 1'b0;
        q0.delete();
        q1.delete();
        last_v[0] = '0;
        last_v[1] = '0;
        foreach (m0[i]) m0[i] = '0;
        foreach (m1[i]) m1[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst_dout0", {16'h0, dout0}, 32'd0);
        chk("rst_dout1", dout1, 32'd0);
        chk("rst_init_done0", {31'd0, init_done0}, 32'd0);
        chk("rst_init_done1", {31'd0, init_done1}, 32'd0);
        reset = 1'b0;
        n = 0; n0 = 0; n1 = 0;
        while ((n0 == 0 || n1 == 0) && n < 5000) begin
            if (n < 4000) begin
                ren   = 1'($urandom_range(0, 1));
                wen   = 1'($urandom_range(0, 1));
                raddr = 14'($urandom_range(0, 15));
                waddr = 14'($urandom_range(0, 15));
                din   = $urandom;
            end else begin
                ren = 1'b0;
                wen = 1'b0;
            end
            @(posedge clock);
            #1;
            n++;
            if (init_done0 && n0 == 0) n0 = n;
            if (init_done1 && n1 == 0) n1 = n;
        end
        chk("init_cycles0", n0, 4096);
        chk("init_cycles1", n1, 4096);
        ren = 1'b0; wen = 1'b0;
        ready = 1'b1;
    endtask

    initial begin
        logic [13:0] ra, wa;
        int          sel;
        reset = 1'b1; ren = 1'b0; wen = 1'b0; raddr = '0; waddr = '0; din = '0;
        do_reset();

        drive(1, 14'd0, 0, 14'd0, 32'h0);
        drive(1, 14'd100, 0, 14'd0, 32'h0);
        drive(1, 14'h3fff, 0, 14'd0, 32'h0);
        drive(0, 14'd0, 1, 14'd5, 32'h0000BEEF);
        for (int a = 4; a < 8; a++) drive(1, 14'(a), 0, 14'd0, 32'h0);
        drive(1, 14'd9, 1, 14'd9, 32'h00001234);
        drive(1, 14'd9, 0, 14'd0, 32'h0);
        drive(0, 14'd0, 1, 14'd1, 32'hDEADBEEF);
        drive(1, 14'd1, 0, 14'd0, 32'h0);
        drive(1, 14'd0, 0, 14'd0, 32'h0);
        repeat (6) drive(0, 14'd0, 0, 14'd0, 32'h0);

        for (int i = 0; i < 10000; i++) begin
            ra  = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 15));
            sel = $urandom_range(0, 7);
            if (sel < 2)      wa = ra;
            else if (sel < 3) wa = ra ^ 14'd1;
            else if (sel < 4) wa = 14'($urandom);
            else              wa = 14'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom);
        end
        repeat (6) drive(0, 14'd0, 0, 14'd0, 32'h0);

        drive(1, 14'd9, 0, 14'd0, 32'h0);
        do_reset();
        for (int a = 0; a < 16; a++) drive(1, 14'(a), 0, 14'd0, 32'h0);
        repeat (8) drive(0, 14'd0, 0, 14'd0, 32'h0);
        chk("drain0", q0.size(), 32'd0);
        chk("drain1", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
